// File: rtl/uv_apb_to_bus_if.sv
// ---------------------------------------------------------------------------
// uv_apb_to_bus_if
//   Signal bundle for uv_apb_to_bus: the APB completer port and the internal
//   valid/ready request/response bus.
//   Modports:
//     slave  - the bridge's view (APB inputs, bus request outputs,
//              bus response inputs)
//     master - the surrounding environment's view (APB initiator plus
//              bus fabric), i.e. the same signals with directions reversed
//   Parameters: ALEN address width, DLEN data width, MLEN byte-mask width.
// ---------------------------------------------------------------------------
interface uv_apb_to_bus_if #(
    parameter int unsigned ALEN = 12,
    parameter int unsigned DLEN = 32,
    parameter int unsigned MLEN = DLEN / 8
);
    // APB side
    logic            apb_psel;
    logic            apb_penable;
    logic [2:0]      apb_pprot;
    logic [ALEN-1:0] apb_paddr;
    logic [MLEN-1:0] apb_pstrb;
    logic            apb_pwrite;
    logic [DLEN-1:0] apb_pwdata;
    logic [DLEN-1:0] apb_prdata;
    logic            apb_pready;
    logic            apb_pslverr;

    // Bus request channel
    logic            bus_req_vld;
    logic            bus_req_rdy;
    logic            bus_req_read;
    logic [ALEN-1:0] bus_req_addr;
    logic [MLEN-1:0] bus_req_mask;
    logic [DLEN-1:0] bus_req_data;

    // Bus response channel
    logic            bus_rsp_vld;
    logic            bus_rsp_rdy;
    logic [1:0]      bus_rsp_excp;
    logic [DLEN-1:0] bus_rsp_data;

    modport slave (
        input  apb_psel, apb_penable, apb_pprot, apb_paddr, apb_pstrb,
               apb_pwrite, apb_pwdata,
        output apb_prdata, apb_pready, apb_pslverr,
        output bus_req_vld, bus_req_read, bus_req_addr, bus_req_mask,
               bus_req_data,
        input  bus_req_rdy,
        input  bus_rsp_vld, bus_rsp_excp, bus_rsp_data,
        output bus_rsp_rdy
    );

    modport master (
        output apb_psel, apb_penable, apb_pprot, apb_paddr, apb_pstrb,
               apb_pwrite, apb_pwdata,
        input  apb_prdata, apb_pready, apb_pslverr,
        input  bus_req_vld, bus_req_read, bus_req_addr, bus_req_mask,
               bus_req_data,
        output bus_req_rdy,
        output bus_rsp_vld, bus_rsp_excp, bus_rsp_data,
        input  bus_rsp_rdy
    );
endinterface

// File: rtl/uv_apb_to_bus.sv
// ---------------------------------------------------------------------------
// uv_apb_to_bus
//   APB completer that turns each APB transfer into exactly one request and
//   one response on the internal valid/ready bus. Single outstanding transfer.
//   All bus and APB-response outputs are registered; apb_pready stays low
//   until the bus response has been accepted, then pulses for one cycle.
//   Ports:
//     clk    - clock, all logic on posedge
//     rst_n  - synchronous active-low reset
//     io     - uv_apb_to_bus_if.slave (APB port + bus request/response)
//   Parameters: ALEN address width, DLEN data width, MLEN byte-mask width.
// ---------------------------------------------------------------------------
module uv_apb_to_bus #(
    parameter int unsigned ALEN = 12,
    parameter int unsigned DLEN = 32,
    parameter int unsigned MLEN = DLEN / 8
) (
    input  logic           clk,
    input  logic           rst_n,
    uv_apb_to_bus_if.slave io
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RSP,
        ST_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Only a setup phase starts a transfer; psel & penable seen in IDLE
    // (no preceding setup) is ignored.
    logic setup;
    assign setup = io.apb_psel & ~io.apb_penable;

    // Protection attributes carry no meaning for this completer.
    logic unused_pprot;
    assign unused_pprot = ^io.apb_pprot;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The APB side is not monitored after the setup phase: once captured,
    // the bus transaction always runs to completion and DONE always pulses.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (setup)           state_nxt = ST_REQ;
            ST_REQ:  if (io.bus_req_rdy)  state_nxt = ST_RSP;
            ST_RSP:  if (io.bus_rsp_vld)  state_nxt = ST_DONE;
            ST_DONE:                      state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next state, so they
    // line up with the state they belong to without combinational paths.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            io.bus_req_vld  <= 1'b0;
            io.bus_req_read <= 1'b0;
            io.bus_req_addr <= '0;
            io.bus_req_mask <= '0;
            io.bus_req_data <= '0;
            io.bus_rsp_rdy  <= 1'b0;
            io.apb_pready   <= 1'b0;
            io.apb_pslverr  <= 1'b0;
            io.apb_prdata   <= '0;
        end else begin
            io.bus_req_vld <= (state_nxt == ST_REQ);
            io.bus_rsp_rdy <= (state_nxt == ST_RSP);
            io.apb_pready  <= (state_nxt == ST_DONE);

            if (state == ST_IDLE && setup) begin
                io.bus_req_read <= ~io.apb_pwrite;
                io.bus_req_addr <= io.apb_paddr;
                io.bus_req_mask <= io.apb_pwrite ? io.apb_pstrb : '1;
                io.bus_req_data <= io.apb_pwrite ? io.apb_pwdata : '0;
            end

            // prdata/pslverr are only non-zero while pready is high.
            if (state == ST_RSP && io.bus_rsp_vld) begin
                io.apb_prdata  <= io.bus_rsp_data;
                io.apb_pslverr <= |io.bus_rsp_excp;
            end else if (state == ST_DONE) begin
                io.apb_prdata  <= '0;
                io.apb_pslverr <= 1'b0;
            end
        end
    end

endmodule
